// File: rtl/reset4_clrseq_if.sv
// ----------------------------------------------------------------------------
// reset4_clrseq_if
// RAM write-port bundle between the clear sequencer and the data RAM.
//
// Handshake: ram_req_o is the request (valid) and ram_ack_i is the accept
// (ready). A word is written in every cycle where both are high. While
// ram_req_o is high, ram_addr_o and ram_wdata_o are stable, and ram_req_o is
// never dropped until it has been acked.
//
// Signals:
//   ram_req_o    master -> slave  write request
//   ram_ack_i    slave  -> master request accepted this cycle
//   ram_addr_o   master -> slave  word address (AWIDTH)
//   ram_wdata_o  master -> slave  write data (DWIDTH)
// ----------------------------------------------------------------------------
interface reset4_clrseq_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
);
    logic              ram_req_o;
    logic              ram_ack_i;
    logic [AWIDTH-1:0] ram_addr_o;
    logic [DWIDTH-1:0] ram_wdata_o;

    modport master (
        output ram_req_o,
        output ram_addr_o,
        output ram_wdata_o,
        input  ram_ack_i
    );

    modport slave (
        input  ram_req_o,
        input  ram_addr_o,
        input  ram_wdata_o,
        output ram_ack_i
    );
endinterface

// File: rtl/reset4_clrseq.sv
// ----------------------------------------------------------------------------
// reset4_clrseq
// Clear sequencer behind the reset4 register file. A ctrl.clrall write of 1
// (with ctrl.ena set) walks all DEPTH RAM words writing FILL; a write of 0
// aborts. ctrl.busy is reported back for the whole sequence, and done_o
// pulses for one cycle when the last word has been written.
//
// Ports:
//   main_clk_i          clock
//   main_rst_an_i       asynchronous reset, active low
//   ctrl_ena_i          enable (regf ctrl.ena)
//   ctrl_clrall_wr_i    regf ctrl.clrall write strobe
//   ctrl_clrall_wbus_i  regf ctrl.clrall write value: 1 = start, 0 = abort
//   ctrl_busy_o         sequence active (regf ctrl.busy)
//   done_o              one-cycle pulse on a completed clear
//   ram                 RAM write port (reset4_clrseq_if.master)
//   dbg_state_o         FSM state: 0 = idle, 1 = run, 2 = pause
//
// Handshake: ram_req_o is valid, ram_ack_i is ready; a word is written when
// both are high. Address and data are stable while the request is pending,
// and the request is only withdrawn in the cycle after an ack.
// ----------------------------------------------------------------------------
module reset4_clrseq #(
    parameter int                DEPTH  = 256,
    parameter int                AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int                DWIDTH = 32,
    parameter logic [DWIDTH-1:0] FILL   = {DWIDTH{1'b0}}
) (
    input  logic                   main_clk_i,
    input  logic                   main_rst_an_i,
    input  logic                   ctrl_ena_i,
    input  logic                   ctrl_clrall_wr_i,
    input  logic                   ctrl_clrall_wbus_i,
    output logic                   ctrl_busy_o,
    output logic                   done_o,
    reset4_clrseq_if.master        ram,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic              r_abort;
    logic              w_abort_nxt;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] w_addr_nxt;

    logic              w_start;
    logic              w_abort_wr;
    logic              w_abort_any;
    logic              w_last;

    assign w_start     = ctrl_clrall_wr_i & ctrl_clrall_wbus_i;
    assign w_abort_wr  = ctrl_clrall_wr_i & ~ctrl_clrall_wbus_i;
    // An abort written in the same cycle as an ack takes effect on that ack.
    assign w_abort_any = r_abort | w_abort_wr;
    // Compare before incrementing so the counter never wraps.
    assign w_last      = (r_addr == LAST_ADDR);

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_abort <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_req   <= w_req_nxt;
            r_abort <= w_abort_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_req_nxt   = r_req;
        w_abort_nxt = r_abort;
        w_addr_nxt  = r_addr;

        case (r_state)
            ST_IDLE: begin
                w_abort_nxt = 1'b0;
                // Starts with ena low and abort writes are ignored here.
                if (w_start && ctrl_ena_i) begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = '0;
                end
            end

            ST_RUN: begin
                w_abort_nxt = w_abort_any;
                if (ram.ram_ack_i) begin
                    if (w_last) begin
                        // Completion wins over a coincident abort.
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_req_nxt   = 1'b0;
                        w_addr_nxt  = '0;
                        w_abort_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (w_abort_any) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_req_nxt   = 1'b0;
                        w_addr_nxt  = '0;
                        w_abort_nxt = 1'b0;
                    end else begin
                        w_addr_nxt = r_addr + AWIDTH'(1);
                        if (!ctrl_ena_i) begin
                            w_state_nxt = ST_PAUSE;
                            w_req_nxt   = 1'b0;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (w_abort_any) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_req_nxt   = 1'b0;
                    w_addr_nxt  = '0;
                    w_abort_nxt = 1'b0;
                end else if (ctrl_ena_i) begin
                    w_state_nxt = ST_RUN;
                    w_req_nxt   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_req_nxt   = 1'b0;
                w_addr_nxt  = '0;
                w_abort_nxt = 1'b0;
            end
        endcase
    end

    assign ctrl_busy_o     = r_busy;
    assign done_o          = r_done;
    assign ram.ram_req_o   = r_req;
    assign ram.ram_addr_o  = r_addr;
    assign ram.ram_wdata_o = FILL;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_reset4_clrseq.sv
// ----------------------------------------------------------------------------
// tb_reset4_clrseq
// Three sequencers (DEPTH 4, 8 and 1) share one set of control inputs and one
// ack line. A reference model per instance, written in terms of "position in
// the walk / paused / abort pending", predicts every output each cycle.
// Directed sequences add hand-written expectations for the corner cases.
// ----------------------------------------------------------------------------
module tb_reset4_clrseq;

    localparam int          N     = 3;
    localparam int          DEP [N] = '{4, 8, 1};
    localparam logic [31:0] FILL4 = 32'hDEAD_BEEF;
    localparam logic [31:0] FILL1 = 32'h1234_5678;
    localparam logic [31:0] FILL_EXP [N] = '{FILL4, 32'h0000_0000, FILL1};

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic ena;
    logic wr;
    logic wbus;
    logic ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic        busy_w  [N];
    logic        done_w  [N];
    logic        req_w   [N];
    logic [15:0] addr_w  [N];
    logic [31:0] wdata_w [N];
    logic [1:0]  dbg_w   [N];

    reset4_clrseq_if #(.AWIDTH(2), .DWIDTH(32)) bus4 ();
    reset4_clrseq_if #(.AWIDTH(3), .DWIDTH(32)) bus8 ();
    reset4_clrseq_if #(.AWIDTH(1), .DWIDTH(32)) bus1 ();

    reset4_clrseq #(.DEPTH(4), .DWIDTH(32), .FILL(FILL4)) u_d4 (
        .main_clk_i(clk), .main_rst_an_i(rst_n), .ctrl_ena_i(ena),
        .ctrl_clrall_wr_i(wr), .ctrl_clrall_wbus_i(wbus),
        .ctrl_busy_o(busy_w[0]), .done_o(done_w[0]), .ram(bus4),
        .dbg_state_o(dbg_w[0])
    );
    reset4_clrseq #(.DEPTH(8)) u_d8 (
        .main_clk_i(clk), .main_rst_an_i(rst_n), .ctrl_ena_i(ena),
        .ctrl_clrall_wr_i(wr), .ctrl_clrall_wbus_i(wbus),
        .ctrl_busy_o(busy_w[1]), .done_o(done_w[1]), .ram(bus8),
        .dbg_state_o(dbg_w[1])
    );
    reset4_clrseq #(.DEPTH(1), .DWIDTH(32), .FILL(FILL1)) u_d1 (
        .main_clk_i(clk), .main_rst_an_i(rst_n), .ctrl_ena_i(ena),
        .ctrl_clrall_wr_i(wr), .ctrl_clrall_wbus_i(wbus),
        .ctrl_busy_o(busy_w[2]), .done_o(done_w[2]), .ram(bus1),
        .dbg_state_o(dbg_w[2])
    );

    assign bus4.ram_ack_i = ack;
    assign bus8.ram_ack_i = ack;
    assign bus1.ram_ack_i = ack;
    assign req_w[0]   = bus4.ram_req_o;
    assign req_w[1]   = bus8.ram_req_o;
    assign req_w[2]   = bus1.ram_req_o;
    assign addr_w[0]  = 16'(bus4.ram_addr_o);
    assign addr_w[1]  = 16'(bus8.ram_addr_o);
    assign addr_w[2]  = 16'(bus1.ram_addr_o);
    assign wdata_w[0] = bus4.ram_wdata_o;
    assign wdata_w[1] = bus8.ram_wdata_o;
    assign wdata_w[2] = bus1.ram_wdata_o;

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;
    int act_nwr   [N];
    int act_ndone [N];
    int exp_nwr   [N];
    int exp_ndone [N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy   [N];
    bit m_paused [N];
    bit m_abort  [N];
    bit m_done   [N];
    int m_pos    [N];

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_busy[d]   = 1'b0;
            m_paused[d] = 1'b0;
            m_abort[d]  = 1'b0;
            m_done[d]   = 1'b0;
            m_pos[d]    = 0;
        end
    endtask

    task automatic model_end(input int d, input bit with_done);
        m_busy[d]   = 1'b0;
        m_paused[d] = 1'b0;
        m_abort[d]  = 1'b0;
        m_pos[d]    = 0;
        if (with_done) begin
            m_done[d] = 1'b1;
            exp_ndone[d]++;
        end
    endtask

    // Advance one clock of the clear walk for instance d.
    task automatic model_step(input int d, input bit i_wr, input bit i_wbus,
                              input bit i_ena, input bit i_ack);
        bit abort_now;
        m_done[d] = 1'b0;
        if (!m_busy[d]) begin
            if (i_wr && i_wbus && i_ena) begin
                m_busy[d]   = 1'b1;
                m_paused[d] = 1'b0;
                m_abort[d]  = 1'b0;
                m_pos[d]    = 0;
            end
        end else begin
            abort_now = m_abort[d] || (i_wr && !i_wbus);
            if (m_paused[d]) begin
                if (abort_now)  model_end(d, 1'b0);
                else if (i_ena) m_paused[d] = 1'b0;
            end else if (i_ack) begin
                exp_nwr[d]++;
                if (m_pos[d] == DEP[d] - 1) model_end(d, 1'b1);
                else if (abort_now)         model_end(d, 1'b0);
                else begin
                    m_pos[d]    = m_pos[d] + 1;
                    m_paused[d] = !i_ena;
                end
            end else begin
                m_abort[d] = abort_now;
            end
        end
    endtask

    task automatic compare_model();
        for (int d = 0; d < N; d++) begin
            chk($sformatf("dut%0d_busy", d), busy_w[d], m_busy[d]);
            chk($sformatf("dut%0d_req", d), req_w[d], m_busy[d] && !m_paused[d]);
            chk($sformatf("dut%0d_addr", d), addr_w[d], m_busy[d] ? m_pos[d] : 0);
            chk($sformatf("dut%0d_done", d), done_w[d], m_done[d]);
            chk($sformatf("dut%0d_dbg", d), dbg_w[d],
                !m_busy[d] ? 0 : (m_paused[d] ? 2 : 1));
            if (req_w[d])
                chk($sformatf("dut%0d_wdata", d), wdata_w[d], FILL_EXP[d]);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive inputs, log the writes that the coming
    // rising edge performs, advance the model, then compare at the next
    // falling edge.
    task automatic step(input bit i_wr, input bit i_wbus, input bit i_ena,
                        input bit i_ack);
        wr   = i_wr;
        wbus = i_wbus;
        ena  = i_ena;
        ack  = i_ack;
        for (int d = 0; d < N; d++) begin
            if (req_w[d] && i_ack) act_nwr[d]++;
            model_step(d, i_wr, i_wbus, i_ena, i_ack);
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++)
            if (done_w[d]) act_ndone[d]++;
        compare_model();
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("%s_dut%0d_busy", tag, d), busy_w[d], 0);
            chk($sformatf("%s_dut%0d_req", tag, d), req_w[d], 0);
            chk($sformatf("%s_dut%0d_done", tag, d), done_w[d], 0);
            chk($sformatf("%s_dut%0d_addr", tag, d), addr_w[d], 0);
        end
    endtask

    task automatic do_reset();
        wr    = 1'b0;
        wbus  = 1'b0;
        ena   = 1'b0;
        ack   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit wr;
        bit wbus;
        bit ena;
        bit ack;
        bit busy;
        bit req;
        int addr;
        bit done;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input bit i_wr, input bit i_wbus, input bit i_ena,
                           input bit i_ack, input bit e_busy, input bit e_req,
                           input int e_addr, input bit e_done);
        vec_t v;
        v.wr = i_wr; v.wbus = i_wbus; v.ena = i_ena; v.ack = i_ack;
        v.busy = e_busy; v.req = e_req; v.addr = e_addr; v.done = e_done;
        tbl.push_back(v);
    endtask

    // Applies table rows [lo, hi] and checks the DEPTH=4 instance.
    task automatic run_table(input string tag, input int lo, input int hi);
        int s_wr;
        int s_done;
        s_wr   = act_nwr[0];
        s_done = act_ndone[0];
        for (int i = lo; i <= hi; i++) begin
            step(tbl[i].wr, tbl[i].wbus, tbl[i].ena, tbl[i].ack);
            chk($sformatf("%s_row%0d_busy", tag, i), busy_w[0], tbl[i].busy);
            chk($sformatf("%s_row%0d_req", tag, i), req_w[0], tbl[i].req);
            chk($sformatf("%s_row%0d_addr", tag, i), addr_w[0], tbl[i].addr);
            chk($sformatf("%s_row%0d_done", tag, i), done_w[0], tbl[i].done);
        end
        chk($sformatf("%s_writes", tag), act_nwr[0] - s_wr, 4);
        chk($sformatf("%s_dones", tag), act_ndone[0] - s_done, 1);
    endtask

    // ---------------- test sequence ----------------
    int s_wr;
    int s_done;

    initial begin
        for (int d = 0; d < N; d++) begin
            act_nwr[d] = 0; act_ndone[d] = 0; exp_nwr[d] = 0; exp_ndone[d] = 0;
        end

        // rows 0..5: ack tied high, one word per cycle
        add_vec(1,1,1,1, 1,1,0,0);
        add_vec(0,0,1,1, 1,1,1,0);
        add_vec(0,0,1,1, 1,1,2,0);
        add_vec(0,0,1,1, 1,1,3,0);
        add_vec(0,0,1,1, 0,0,0,1);
        add_vec(0,0,1,1, 0,0,0,0);
        // rows 6..14: ack pattern 0,1,0,0,1,1,1 against addresses 0,0,1,1,1,2,3
        add_vec(1,1,1,0, 1,1,0,0);
        add_vec(0,0,1,0, 1,1,0,0);
        add_vec(0,0,1,1, 1,1,1,0);
        add_vec(0,0,1,0, 1,1,1,0);
        add_vec(0,0,1,0, 1,1,1,0);
        add_vec(0,0,1,1, 1,1,2,0);
        add_vec(0,0,1,1, 1,1,3,0);
        add_vec(0,0,1,1, 0,0,0,1);
        add_vec(0,0,1,0, 0,0,0,0);

        do_reset();
        run_table("ack_high", 0, 5);
        do_reset();
        run_table("ack_pattern", 6, 14);

        // pause on DEPTH=8: ena dropped on the ack of address 2
        do_reset();
        s_wr = act_nwr[1];
        step(1,1,1,1);
        step(0,0,1,1);
        step(0,0,1,1);
        chk("pause_pre_addr", addr_w[1], 2);
        step(0,0,0,1);
        chk("pause_req", req_w[1], 0);
        chk("pause_busy", busy_w[1], 1);
        chk("pause_addr", addr_w[1], 3);
        for (int k = 0; k < 5; k++) begin
            step(0,0,0,1);
            chk($sformatf("pause_hold%0d_req", k), req_w[1], 0);
            chk($sformatf("pause_hold%0d_busy", k), busy_w[1], 1);
        end
        step(0,0,1,0);
        chk("resume_req", req_w[1], 1);
        chk("resume_addr", addr_w[1], 3);
        for (int a = 4; a <= 7; a++) begin
            step(0,0,1,1);
            chk($sformatf("resume_addr%0d", a), addr_w[1], a);
        end
        step(0,0,1,1);
        chk("pause_done", done_w[1], 1);
        chk("pause_end_busy", busy_w[1], 0);
        chk("pause_writes", act_nwr[1] - s_wr, 8);

        // abort on DEPTH=8 while address 4 waits for its ack
        do_reset();
        s_wr   = act_nwr[1];
        s_done = act_ndone[1];
        step(1,1,1,1);
        for (int a = 1; a <= 4; a++) step(0,0,1,1);
        chk("abort_pre_addr", addr_w[1], 4);
        step(1,0,1,0);
        chk("abort_hold_req", req_w[1], 1);
        chk("abort_hold_addr", addr_w[1], 4);
        step(0,0,1,0);
        chk("abort_hold2_req", req_w[1], 1);
        step(0,0,1,1);
        chk("abort_busy", busy_w[1], 0);
        chk("abort_req", req_w[1], 0);
        chk("abort_addr", addr_w[1], 0);
        repeat (3) step(0,0,1,1);
        chk("abort_after_req", req_w[1], 0);
        chk("abort_writes", act_nwr[1] - s_wr, 5);
        chk("abort_no_done", act_ndone[1] - s_done, 0);

        // abort coinciding with the last ack on DEPTH=4: completion wins
        do_reset();
        step(1,1,1,1);
        repeat (3) step(0,0,1,1);
        chk("abort_last_pre", addr_w[0], 3);
        step(1,0,1,1);
        chk("abort_last_done", done_w[0], 1);
        chk("abort_last_busy", busy_w[0], 0);

        // start with ena low ignored; second start mid-run ignored
        do_reset();
        step(1,1,0,1);
        chk("start_noena_busy", busy_w[1], 0);
        chk("start_noena_req", req_w[1], 0);
        step(0,0,1,0);
        s_done = act_ndone[1];
        step(1,1,1,0);
        chk("restart_addr0", addr_w[1], 0);
        step(0,0,1,1);
        step(0,0,1,1);
        chk("restart_pre", addr_w[1], 2);
        step(1,1,1,1);
        chk("restart_ack_addr", addr_w[1], 3);
        step(1,1,1,0);
        chk("restart_noack_addr", addr_w[1], 3);
        for (int a = 4; a <= 7; a++) begin
            step(0,0,1,1);
            chk($sformatf("restart_addr%0d", a), addr_w[1], a);
        end
        step(0,0,1,1);
        step(0,0,1,0);
        chk("restart_dones", act_ndone[1] - s_done, 1);

        // DEPTH=1 clears a single word
        do_reset();
        step(1,1,1,0);
        chk("d1_busy", busy_w[2], 1);
        chk("d1_req", req_w[2], 1);
        step(0,0,1,0);
        chk("d1_hold_req", req_w[2], 1);
        step(0,0,1,1);
        chk("d1_done", done_w[2], 1);
        chk("d1_busy_end", busy_w[2], 0);
        step(0,0,1,1);
        chk("d1_done_pulse", done_w[2], 0);

        // asynchronous reset in the middle of a clear at address 5
        do_reset();
        step(1,1,1,1);
        for (int a = 1; a <= 5; a++) step(0,0,1,1);
        chk("mid_reset_pre", addr_w[1], 5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        s_wr = act_nwr[1];
        step(1,1,1,1);
        chk("fresh_addr0", addr_w[1], 0);
        for (int a = 1; a <= 7; a++) step(0,0,1,1);
        step(0,0,1,1);
        chk("fresh_done", done_w[1], 1);
        chk("fresh_writes", act_nwr[1] - s_wr, 8);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
            end
        end

        for (int d = 0; d < N; d++) begin
            chk($sformatf("dut%0d_total_writes", d), act_nwr[d], exp_nwr[d]);
            chk($sformatf("dut%0d_total_dones", d), act_ndone[d], exp_ndone[d]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
